// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
// Build option: REGFILE_DUMP_SKIP_X0_EN starts the walk at x1 instead of x0.
package regfile_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int NUM_REGS = 32;

`ifdef REGFILE_DUMP_SKIP_X0_EN
    // x0 is hardwired to zero, so it is left out of the stream.
    localparam int FIRST_IDX = 1;
`else
    localparam int FIRST_IDX = 0;
`endif

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready output stream of the dump engine: one (index, value) beat per transfer.
interface regfile_dump_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_out_stage.sv
// One-entry output register for the dump stream. A load overwrites the entry;
// without a load the entry empties when the downstream accepts it.
// The payload is frozen while valid is high and ready is low.
module regfile_dump_out_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  last_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic                  last_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_d, valid_q;
    logic                  last_d,  last_q;
    logic [ADDR_WIDTH-1:0] addr_d,  addr_q;
    logic [DATA_WIDTH-1:0] data_d,  data_q;

    // Next entry: load wins, otherwise an accepted beat empties the slot.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            addr_d  = addr_i;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks every register index through one read port
// and streams (index, value) beats out over a valid/ready interface.
// Build option: REGFILE_DUMP_SKIP_X0_EN (see regfile_dump_pkg) skips x0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_i; rs_o parked at 0, busy_o low
// ST_READ  | driving rs_o = idx, capturing one register per free slot
// ST_DRAIN | last index captured; waiting for the final beat to be taken
module regfile_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rs_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    regfile_dump_if.master        out_if
);
    import regfile_dump_pkg::*;

    state_e                state_d, state_q;
    logic [ADDR_WIDTH-1:0] idx_d,   idx_q;
    logic                  busy_d,  busy_q;
    logic                  done_d,  done_q;

    logic                  out_valid;
    logic                  load;
    logic                  idx_last;

    // Terminal index is checked on the current value, before any increment.
    assign idx_last = (idx_q == {ADDR_WIDTH{1'b1}});
    assign load     = (state_q == ST_READ) && (!out_valid || out_if.out_ready);

    // Sequencer next state; the index only advances on a successful capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_READ;
                    idx_d   = ADDR_WIDTH'(FIRST_IDX);
                    busy_d  = 1'b1;
                end
            end
            ST_READ: begin
                if (load) begin
                    if (idx_last) state_d = ST_DRAIN;
                    else          idx_d   = idx_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_if.out_ready) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer registers; reset aborts any dump in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    regfile_dump_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_out_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .last_i  (idx_last),
        .addr_i  (idx_q),
        .data_i  (rdata_i),
        .ready_i (out_if.out_ready),
        .valid_o (out_valid),
        .last_o  (out_if.out_last),
        .addr_o  (out_if.out_addr),
        .data_o  (out_if.out_data)
    );

    assign out_if.out_valid = out_valid;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign rs_o             = idx_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed/randomized bench for regfile_dump with a behavioural register file.
module tb_regfile_dump;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;
`ifdef REGFILE_DUMP_SKIP_X0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NBEATS = NREGS - FIRST;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rs;
    logic [DW-1:0] rdata;
    logic [DW-1:0] rf [NREGS];

    int n_cmp = 0;
    int n_err = 0;

    regfile_dump_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) out_if ();

    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .rs_o    (rs),
        .rdata_i (rdata),
        .out_if  (out_if)
    );

    always #5 clk = ~clk;

    assign rdata = rf[rs];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_rs"},    rs, 0);
        chk({tag, "_valid"}, out_if.out_valid, 0);
        chk({tag, "_addr"},  out_if.out_addr, 0);
        chk({tag, "_data"},  out_if.out_data, 0);
        chk({tag, "_last"},  out_if.out_last, 0);
    endtask

    // One dump, observed at falling edges. rmode: 0 ready=1, 1 ready 1,0,0,..., 2 random.
    // abort_at>0 pulls reset after that many accepted beats; wr_idx>=0 writes DEADBEEF there mid-dump.
    task automatic run_dump(input bit do_start, input bit hold, input int rmode,
                            input int abort_at, input int wr_idx);
        int            exp_idx = FIRST;
        int            beats   = 0;
        int            cyc     = 0;
        bit            prev_acc_last = 1'b0;
        bit            prev_stall    = 1'b0;
        bit            written = 1'b0;
        bit            fin     = 1'b0;
        bit            acc, exp_last;
        logic [AW-1:0] p_addr, p_rs;
        logic [DW-1:0] p_data;
        logic          p_last;
        p_addr = '0; p_rs = '0; p_data = '0; p_last = 1'b0;
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = hold;
        end
        chk("lat_busy",  busy, 1);
        chk("lat_valid", out_if.out_valid, 0);
        chk("lat_rs",    rs, FIRST);
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            case (rmode)
                0:       out_if.out_ready = 1'b1;
                1:       out_if.out_ready = (cyc % 3 == 1);
                default: out_if.out_ready = 1'($urandom_range(0, 1));
            endcase
            chk("done", done, prev_acc_last);
            chk("busy", busy, !prev_acc_last);
            if (prev_acc_last) begin
                fin = 1'b1;
            end else begin
                if (cyc == 1) chk("first_valid", out_if.out_valid, 1);
                if (rmode == 0) chk("thru_valid", out_if.out_valid, 1);
                if (prev_stall) begin
                    chk("stall_valid", out_if.out_valid, 1);
                    chk("stall_addr",  out_if.out_addr, p_addr);
                    chk("stall_data",  out_if.out_data, p_data);
                    chk("stall_last",  out_if.out_last, p_last);
                    chk("stall_rs",    rs, p_rs);
                end
                if (wr_idx >= 0 && !written && rs == AW'(wr_idx - 1)) begin
                    rf[wr_idx] = 32'hDEAD_BEEF;
                    written    = 1'b1;
                end
                acc      = out_if.out_valid && out_if.out_ready;
                exp_last = (exp_idx == NREGS - 1);
                if (acc) begin
                    chk("beat_addr", out_if.out_addr, exp_idx);
                    chk("beat_data", out_if.out_data, rf[exp_idx]);
                    chk("beat_last", out_if.out_last, exp_last);
                    beats++;
                    exp_idx++;
                end
                prev_acc_last = acc && exp_last;
                prev_stall    = out_if.out_valid && !out_if.out_ready;
                p_addr = out_if.out_addr;
                p_data = out_if.out_data;
                p_last = out_if.out_last;
                p_rs   = rs;
                if (abort_at > 0 && beats == abort_at) begin
                    #2 rst_n = 1'b0;
                    #1 chk_reset("abort");
                    @(negedge clk);
                    chk_reset("abort_hold");
                    rst_n = 1'b1;
                    fin   = 1'b1;
                end
            end
        end
        chk("finished", fin, 1);
        if (abort_at == 0) chk("beat_count", beats, NBEATS);
        if (abort_at == 0 && rmode == 0) chk("done_timing", cyc, NBEATS + 1);
        if (wr_idx >= 0) chk("wr_applied", written, 1);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) rf[i] = 32'h1000_0000 + i;
        out_if.out_ready = 1'b1;
        #12;
        chk_reset("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("idle");

        // Full dump, ready always high.
        run_dump(1'b1, 1'b0, 0, 0, -1);
        // Backpressure 1,0,0 pattern.
        run_dump(1'b1, 1'b0, 1, 0, -1);
        // Random contents and random ready.
        for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
        run_dump(1'b1, 1'b0, 2, 0, -1);

        // start held through a dump: one dump, restart from the done cycle.
        run_dump(1'b1, 1'b1, 0, 0, -1);
        @(negedge clk);
        start = 1'b0;
        run_dump(1'b0, 1'b0, 0, 0, -1);
        @(negedge clk);
        chk("no_third_busy", busy, 0);
        chk("no_third_valid", out_if.out_valid, 0);

        // Reset mid-dump, then a clean full dump.
        run_dump(1'b1, 1'b0, 2, 10, -1);
        run_dump(1'b1, 1'b0, 0, 0, -1);

        // Write landing before x20 is captured.
        run_dump(1'b1, 1'b0, 2, 0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine that walks every architectural register through one read port of the 32×32 register file and streams each `(index, value)` pair out over a valid/ready interface. It is used for debug snapshots and end-of-test register dumps. The block sits beside the register file and owns the read address of the port muxed to it while `busy_o` is high. The register file itself is unchanged: reads are combinational and writes land on the falling clock edge.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register width.
- `ADDR_WIDTH`, 5: register index width; `2**ADDR_WIDTH` registers are dumped.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request a dump; sampled only in IDLE.
- `busy_o`  out  1  high from the cycle after start is accepted until the final beat is accepted.
- `done_o`  out  1  one-cycle pulse, the cycle after the final beat is accepted.
- `rs_o`  out  ADDR_WIDTH  read address driven to the register file port.
- `rdata_i`  in  DATA_WIDTH  combinational read data for `rs_o`.
- `out_valid_o`  out  1  output beat valid.
- `out_ready_i`  in  1  downstream accepts the beat.
- `out_addr_o`  out  ADDR_WIDTH  register index of the beat.
- `out_data_o`  out  DATA_WIDTH  register value of the beat.
- `out_last_o`  out  1  beat is the final one of the dump.

## Operation
- States:
  - IDLE: `rs_o`=0, `busy_o`=0.
  - READ: issues indices.
  - DRAIN: waits for the last beat to be accepted.
- IDLE → READ on `start_i`=1. The index counter loads FIRST (0, or 1 with the skip option).
- READ, per cycle, with `rs_o`=idx:
  - If `!out_valid_o || out_ready_i`: load `out_data_o`=`rdata_i`, `out_addr_o`=idx, `out_last_o`=(idx==all-ones), `out_valid_o`=1.
  - After that load: if idx is all-ones, go to DRAIN; otherwise idx+1.
  - If the load is stalled, idx and `rs_o` hold.
- DRAIN:
  - When `out_valid_o && out_ready_i`: clear `out_valid_o`, pulse `done_o`, return to IDLE.
  - An output beat alone (valid without ready) holds.
- The index counter never wraps. The terminal index is compared before the increment.
- `start_i` while busy is ignored. No queued restart.
- Output payload holds stable while `out_valid_o`=1 and `out_ready_i`=0.
- Register writes landing on the falling edge during a dump are visible if they precede the capturing rising edge. The dump is not an atomic snapshot.

## Timing
- Reset values: state IDLE, idx 0, `rs_o`=0, `busy_o`=0, `done_o`=0, `out_valid_o`=0, `out_addr_o`=0, `out_data_o`=0, `out_last_o`=0.
- Reset asserted mid-dump aborts immediately (asynchronously). The partial stream is discarded and no `done_o` is produced.
- Latency: `start_i` at edge N gives the first beat valid after edge N+1.
- Throughput: with `out_ready_i` held at 1, one beat per cycle. A 32-register dump is valid for 32 consecutive cycles, and `done_o` pulses one cycle after the last beat.
- `done_o` and `start_i` in the same cycle: the start is accepted only from IDLE, so the earliest restart is the cycle `done_o` is high.

## Configuration
- `REGFILE_DUMP_SKIP_X0_EN` defined:
  - FIRST=1 and x0 is never read.
  - A full dump is `2**ADDR_WIDTH-1` beats.
- `REGFILE_DUMP_SKIP_X0_EN` undefined:
  - FIRST=0.
  - x0 is emitted, with value 0 for a correct register file.
  - A full dump is `2**ADDR_WIDTH` beats.
- The option does not change the terminal index or the `out_last_o` rule.

## Structure
- Package `regfile_dump_pkg` holds:
  - the state enum (IDLE, READ, DRAIN);
  - the `NUM_REGS` constant;
  - the `FIRST_IDX` constant, selected by the macro.
- Sub-module `regfile_dump_out_stage`: a one-entry valid/ready output register with the load/hold logic, payload = {last, addr, data}.
- The top level holds the FSM and the index counter.

## Test plan
- Register file preloaded with x_i = 0x1000_0000+i, `out_ready_i`=1, pulse `start_i` → 32 consecutive beats with addr 0..31 and data 0x1000_0000..0x1000_001F. `out_last_o` is set only on addr 31. `done_o` pulses one cycle later.
- Backpressure: `out_ready_i` toggles 1,0,0,1,… → no beat is lost or duplicated. Payload is stable while stalled. `rs_o` holds during stalls.
- `start_i` held high through a whole dump → exactly one dump, then a second dump starting the cycle `done_o` is high.
- `rst_n` pulled low after beat 10 → all outputs return to their reset values at once. No `done_o`. A new start produces a full dump from index FIRST.
- Register file write of 0xDEAD_BEEF to x20 on the falling edge before x20 is captured → beat 20 carries 0xDEAD_BEEF.
- With `REGFILE_DUMP_SKIP_X0_EN` → 31 beats, first addr 1, last addr 31 with `out_last_o`=1.
